// File: rtl/addsub_n_parts_if.sv
// Handshake and operand bus for the limb-serial adder/subtractor.
// The res_zero signal only exists when ADDSUB_ZERO_FLAG_EN is defined.
interface addsub_n_parts_if #(
   parameter int SIZE = 896
);
   logic            start;
   logic            op;
   logic [SIZE-1:0] a;
   logic [SIZE-1:0] b;
   logic [SIZE:0]   result;
   logic            done;
   logic            busy;
`ifdef ADDSUB_ZERO_FLAG_EN
   logic            res_zero;
`endif

   modport master (
      output start, op, a, b,
      input  result, done, busy
`ifdef ADDSUB_ZERO_FLAG_EN
      , input res_zero
`endif
   );

   modport slave (
      input  start, op, a, b,
      output result, done, busy
`ifdef ADDSUB_ZERO_FLAG_EN
      , output res_zero
`endif
   );
endinterface

// File: rtl/addsub_n_parts.sv
// Multi-cycle limb-serial adder/subtractor for wide EdDSA operands.
// One LIMB = SIZE/PARTS slice is processed per clock; carry/borrow ripples
// between limbs through a one-bit register. SIZE must be divisible by PARTS.
// Optional macro ADDSUB_ZERO_FLAG_EN adds a res_zero output built from an
// OR-accumulator over the limb results, avoiding a separate wide comparator.
module addsub_n_parts #(
   parameter int SIZE  = 896,
   parameter int PARTS = 8
) (
   input logic              clk,
   input logic              rst_n,
   addsub_n_parts_if.slave  bus
);
   localparam int LIMB = SIZE / PARTS;
   localparam int CW   = (PARTS > 1) ? $clog2(PARTS) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [SIZE-1:0] a_q, a_d;
   logic [SIZE-1:0] b_q, b_d;
   logic [SIZE-1:0] stage_q, stage_d;
   logic [SIZE:0]   result_q, result_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            op_q, op_d;
   logic            carry_q, carry_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;

   logic [LIMB:0]        limb_sum;
   logic [SIZE+LIMB-1:0] stage_cat;
   logic                 last_limb;

`ifdef ADDSUB_ZERO_FLAG_EN
   logic zacc_q, zacc_d;
   logic res_zero_q, res_zero_d;
`endif

   // Limb arithmetic on LIMB+1 bits; the top bit is the outgoing carry or borrow
   always_comb begin
      limb_sum = '0;
      if (op_q)
         limb_sum = {1'b0, a_q[LIMB-1:0]} - {1'b0, b_q[LIMB-1:0]} - {{LIMB{1'b0}}, carry_q};
      else
         limb_sum = {1'b0, a_q[LIMB-1:0]} + {1'b0, b_q[LIMB-1:0]} + {{LIMB{1'b0}}, carry_q};
      stage_cat = {limb_sum[LIMB-1:0], stage_q};
      last_limb = (cnt_q == CW'(PARTS - 1));
   end

   // Next-state logic: operands shift down one limb per cycle, results shift in from the top
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      stage_d  = stage_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      carry_d  = carry_q;
      done_d   = done_q;
      busy_d   = busy_q;
`ifdef ADDSUB_ZERO_FLAG_EN
      zacc_d     = zacc_q;
      res_zero_d = res_zero_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               op_d    = bus.op;
               cnt_d   = '0;
               carry_d = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               state_d = RUN;
`ifdef ADDSUB_ZERO_FLAG_EN
               zacc_d  = 1'b0;
`endif
            end
         end
         RUN: begin
            a_d     = a_q >> LIMB;
            b_d     = b_q >> LIMB;
            carry_d = limb_sum[LIMB];
            stage_d = stage_cat[SIZE+LIMB-1:LIMB];
`ifdef ADDSUB_ZERO_FLAG_EN
            zacc_d  = zacc_q | (|limb_sum[LIMB-1:0]);
`endif
            if (last_limb) begin
               result_d = {limb_sum[LIMB], stage_d};
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
`ifdef ADDSUB_ZERO_FLAG_EN
               res_zero_d = ~(zacc_d | limb_sum[LIMB]);
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-low reset that abandons any operation
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         stage_q  <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         op_q     <= 1'b0;
         carry_q  <= 1'b0;
         done_q   <= 1'b1;
         busy_q   <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
         zacc_q     <= 1'b0;
         res_zero_q <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         stage_q  <= stage_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         carry_q  <= carry_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
`ifdef ADDSUB_ZERO_FLAG_EN
         zacc_q     <= zacc_d;
         res_zero_q <= res_zero_d;
`endif
      end
   end

   assign bus.result = result_q;
   assign bus.done   = done_q;
   assign bus.busy   = busy_q;
`ifdef ADDSUB_ZERO_FLAG_EN
   assign bus.res_zero = res_zero_q;
`endif
endmodule

// File: tb/tb_addsub_n_parts.sv
// Directed bench for addsub_n_parts: 896/8, 32/4 and 32/1 configurations.
// Also exercises res_zero when ADDSUB_ZERO_FLAG_EN is defined.
module tb_addsub_n_parts;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   addsub_n_parts_if #(.SIZE(896)) bus0 ();
   addsub_n_parts_if #(.SIZE(32))  bus1 ();
   addsub_n_parts_if #(.SIZE(32))  bus2 ();

   addsub_n_parts #(.SIZE(896), .PARTS(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   addsub_n_parts #(.SIZE(32),  .PARTS(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   addsub_n_parts #(.SIZE(32),  .PARTS(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and report a short tag with observed/expected on mismatch
   task automatic checkOutput(input string tag, input logic [896:0] obs, input logic [896:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed top=%b hi=%h lo=%h expected top=%b hi=%h lo=%h diffbits=%0d",
                tag, obs[896], obs[895:832], obs[63:0], exp[896], exp[895:832], exp[63:0],
                $countones(obs ^ exp));
      end
   endtask

   function automatic logic doneOf(input int which);
      case (which)
         0:       return bus0.done;
         1:       return bus1.done;
         default: return bus2.done;
      endcase
   endfunction

   function automatic logic [896:0] resultOf(input int which);
      case (which)
         0:       return bus0.result;
         1:       return 897'(bus1.result);
         default: return 897'(bus2.result);
      endcase
   endfunction

   // Pulse start on one DUT, scramble inputs after the start edge, count busy cycles until done
   task automatic applyStimulus(input int which, input logic opv, input logic [895:0] av,
                                input logic [895:0] bv, output logic [896:0] res, output int cycles);
      @(negedge clk);
      case (which)
         0:       begin bus0.op = opv; bus0.a = av;        bus0.b = bv;        bus0.start = 1'b1; end
         1:       begin bus1.op = opv; bus1.a = av[31:0];  bus1.b = bv[31:0];  bus1.start = 1'b1; end
         default: begin bus2.op = opv; bus2.a = av[31:0];  bus2.b = bv[31:0];  bus2.start = 1'b1; end
      endcase
      @(posedge clk);
      #1;
      bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
      bus0.a = ~av; bus0.b = ~bv; bus0.op = ~opv;
      bus1.a = ~av[31:0]; bus1.b = ~bv[31:0]; bus1.op = ~opv;
      bus2.a = ~av[31:0]; bus2.b = ~bv[31:0]; bus2.op = ~opv;
      cycles = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (doneOf(which)) break;
         cycles++;
      end
      res = resultOf(which);
   endtask

   // Directed test sequence
   initial begin
      logic [895:0] ones;
      logic [895:0] rv;
      logic [896:0] res;
      logic [896:0] pow896;
      int           cycles;
      int           glitches;

      total = 0;
      bad   = 0;
      ones  = '1;
      pow896 = 897'(1) << 896;
      rst_n = 1'b0;
      bus0.start = 1'b0; bus0.op = 1'b0; bus0.a = '0; bus0.b = '0;
      bus1.start = 1'b0; bus1.op = 1'b0; bus1.a = '0; bus1.b = '0;
      bus2.start = 1'b0; bus2.op = 1'b0; bus2.a = '0; bus2.b = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("rst_res", bus0.result, '0);
      checkOutput("rst_done", 897'(bus0.done), 897'(1));
      checkOutput("rst_busy", 897'(bus0.busy), 897'(0));
`ifdef ADDSUB_ZERO_FLAG_EN
      checkOutput("rst_zero", 897'(bus0.res_zero), 897'(1));
`endif
      repeat (10) @(negedge clk);
      checkOutput("idle_res", bus0.result, '0);
      checkOutput("idle_done", 897'(bus0.done), 897'(1));
      checkOutput("idle_busy", 897'(bus0.busy), 897'(0));

      applyStimulus(0, 1'b0, ones, 896'(1), res, cycles);
      checkOutput("add_ripple", res, pow896);
      checkOutput("add_lat", 897'(cycles), 897'(8));

      applyStimulus(0, 1'b1, '0, 896'(1), res, cycles);
      checkOutput("sub_borrow", res, '1);
      applyStimulus(0, 1'b1, 896'(5), 896'(3), res, cycles);
      checkOutput("sub_5_3", res, 897'(2));

      for (int i = 0; i < 28; i++) rv[i*32 +: 32] = $urandom;
      applyStimulus(0, 1'b1, rv, rv, res, cycles);
      checkOutput("sub_equal", res, '0);
`ifdef ADDSUB_ZERO_FLAG_EN
      checkOutput("zero_set", 897'(bus0.res_zero), 897'(1));
`endif
      applyStimulus(0, 1'b0, 896'(1), '0, res, cycles);
      checkOutput("add_1_0", res, 897'(1));
`ifdef ADDSUB_ZERO_FLAG_EN
      checkOutput("zero_clr", 897'(bus0.res_zero), 897'(0));
`endif

      // start held high through the whole operation with new operands
      @(negedge clk);
      bus0.op = 1'b0; bus0.a = 896'(10); bus0.b = 896'(20); bus0.start = 1'b1;
      @(posedge clk);
      #1;
      bus0.op = 1'b1; bus0.a = 896'(100); bus0.b = 896'(7);
      cycles = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus0.done) break;
         cycles++;
      end
      checkOutput("ign_res", bus0.result, 897'(30));
      checkOutput("ign_lat", 897'(cycles), 897'(8));
      checkOutput("ign_busy", 897'(bus0.busy), 897'(0));
      @(posedge clk);
      #1;
      bus0.start = 1'b0; bus0.a = '0; bus0.b = '0; bus0.op = 1'b0;
      cycles = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus0.done) break;
         cycles++;
      end
      checkOutput("b2b_res", bus0.result, 897'(93));
      checkOutput("b2b_lat", 897'(cycles), 897'(8));

      // reset in the middle of a run
      @(negedge clk);
      bus0.op = 1'b0; bus0.a = ones; bus0.b = 896'(1); bus0.start = 1'b1;
      @(posedge clk);
      #1;
      bus0.start = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("mid_busy", 897'(bus0.busy), 897'(1));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("mid_res", bus0.result, '0);
      checkOutput("mid_done", 897'(bus0.done), 897'(1));
      checkOutput("mid_bsy0", 897'(bus0.busy), 897'(0));
      glitches = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus0.done !== 1'b1 || bus0.result !== '0) glitches++;
      end
      checkOutput("mid_quiet", 897'(glitches), 897'(0));

      applyStimulus(1, 1'b0, 896'h0FFFF_FFFF, 896'(1), res, cycles);
      checkOutput("p4_add", res, 897'h1_0000_0000);
      checkOutput("p4_lat", 897'(cycles), 897'(4));

      applyStimulus(2, 1'b1, 896'(3), 896'(5), res, cycles);
      checkOutput("p1_sub", res, 897'h1_FFFF_FFFE);
      checkOutput("p1_lat", 897'(cycles), 897'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
